prach_buffer_readout_rr: RTL and testbench
==========================================

// Module: prach_buffer_readout_rr
// PURPOSE
//  Arbitrates NUM_CH PRACH sample buffers that signal "block complete".
//  Reads one block of cfg_len samples from the granted buffer and streams it to the FFT.
//  Supports downstream backpressure through a credit-controlled skid FIFO.
//  Tags every output sample with its source channel, first-sample and last-sample flags.
// PARAMETERS
//  NUM_CH  24  number of buffers (cc x ant); CH_W = $clog2(NUM_CH)
//  ADDR_W  11  buffer address width
//  DATA_W  32  sample width: [DATA_W/2-1:0]=I, [DATA_W-1:DATA_W/2]=Q
//  RD_LAT  2   buffer read latency, rd_en/rd_addr -> rd_data valid (>=1)
// PORTS
//  clk       in   1             clock
//  rst_n     in   1             synchronous reset, active-low
//  cfg_len   in   ADDR_W        block length; 0 => 2**ADDR_W; latched at grant
//  done_req  in   NUM_CH        per-buffer block-ready request (level)
//  done_ack  out  NUM_CH        one-hot grant, held for the whole block read
//  rd_addr   out  ADDR_W        shared read address
//  rd_en     out  NUM_CH        read strobe, granted channel only, one per issued read
//  rd_data   in   NUM_CH*DATA_W per-buffer read data, valid RD_LAT cycles after rd_en
//  dout_ready in  1             FFT accepts sample when dout_dv && dout_ready
//  dout_dr   out  DATA_W/2      I sample
//  dout_di   out  DATA_W/2      Q sample
//  dout_dv   out  1             sample valid
//  dout_ch   out  CH_W          source channel of sample
//  sync_out  out  1             first sample of block
//  last_out  out  1             last sample of block
// BEHAVIOUR
//  Reset: every output is 0; FSM=IDLE; FIFO empty; RR pointer=0.
//  FSM states:
//   IDLE  -> GRANT when any done_req=1 (sampled only in IDLE).
//   GRANT -> one cycle. Latch winner idx and len; assert done_ack[idx].
//   READ  -> issue reads at addr 0..len-1. Stay until last address issued.
//   FLUSH -> wait RD_LAT cycles for the final read data to land in the FIFO.
//            Then drop done_ack and go to IDLE.
//  Issue rule: read issued in cycle t iff state=READ && fifo_cnt+inflight < DEPTH.
//   DEPTH = RD_LAT+2.
//   Issued read: rd_en[idx]=1 and rd_addr=current; otherwise rd_en all 0 and rd_addr holds.
//   Full throughput (1 sample/clk) while dout_ready=1.
//  Data path: rd_data[idx] muxed by latched idx (no OR-combining); written into FIFO
//   RD_LAT cycles after issue, together with idx, first and last tags.
//  Output: dout_* registered from FIFO head. dout_dv=1 while FIFO is non-empty.
//   Held stable while dout_dv && !dout_ready.
//   Minimum latency rd_en -> dout_dv = RD_LAT+1.
//  FIFO never overflows (credit rule). A block's samples drain after ack release.
//   The next block's samples follow with no bubble required.
//  Requests: done_req changes during GRANT/READ/FLUSH are ignored.
//   A requester keeping done_req=1 after ack drop is re-arbitrated normally.
//  At least one IDLE cycle between ack drop and the next grant.
//  len=1: the single sample has sync_out=last_out=1.
//  len=0 is read as 2**ADDR_W: rd_addr wraps to 0 only after the final address.
//  cfg_len changes mid-block are not applied until the next grant.
//  rst_n low mid-block: immediate abort. Ack/rd_en drop; FIFO and in-flight data discarded.
// CONFIGURATION
//  PRACH_READOUT_RR_EN defined: round-robin arbitration.
//   Search starts at (last granted idx+1) mod NUM_CH.
//  PRACH_READOUT_RR_EN undefined: fixed priority, lowest index wins; RR pointer absent.
// TESTING
//  1. done_req[5]=1, cfg_len=4, ready=1 -> ack[5]; addrs 0..3 on consecutive cycles;
//     4 samples with dout_ch=5, sync on 1st, last on 4th.
//  2. done_req[0]=done_req[7]=1 held -> fixed: 0,7,0,7 order impossible, 0 repeats;
//     RR_EN: grants alternate 0,7,0,7.
//  3. cfg_len=16; dout_ready toggles 1/0 every 3 cycles -> no lost or duplicated sample;
//     data = addr pattern in order; fifo_cnt <= RD_LAT+2.
//  4. cfg_len=0, ADDR_W=4 -> 16 samples; addr 15 then wrap to 0; last_out on 16th.
//  5. cfg_len=1 -> single sample with sync_out=last_out=1; ack high exactly RD_LAT+2 cycles.
//  6. rst_n=0 during READ at addr 7 -> next cycle all outputs 0;
//     after release a new request starts at addr 0.

Source files
------------

// File: rtl/prach_buffer_readout_rr_if.sv
// Output sample stream from the PRACH buffer readout to the FFT.
// master drives samples and tags; slave returns dout_ready.
interface prach_buffer_readout_rr_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = 5
);
    logic [DATA_W/2-1:0] dout_dr;
    logic [DATA_W/2-1:0] dout_di;
    logic                dout_dv;
    logic                dout_ready;
    logic [CH_W-1:0]     dout_ch;
    logic                sync_out;
    logic                last_out;

    modport master (
        output dout_dr, dout_di, dout_dv,
        output dout_ch, sync_out, last_out,
        input  dout_ready
    );

    modport slave (
        input  dout_dr, dout_di, dout_dv,
        input  dout_ch, sync_out, last_out,
        output dout_ready
    );
endinterface

// File: rtl/prach_buffer_readout_rr.sv
// PRACH buffer readout: grants one of NUM_CH "block complete" buffers,
// reads cfg_len samples (0 => 2**ADDR_W) and streams them to the FFT.
// Ports: clk, rst_n (sync, active-low), cfg_len, done_req/done_ack,
// rd_addr/rd_en/rd_data (buffer side), dout (stream master modport).
// Define PRACH_READOUT_RR_EN for round-robin; default is fixed priority.
module prach_buffer_readout_rr #(
    parameter  int NUM_CH = 24,
    parameter  int ADDR_W = 11,
    parameter  int DATA_W = 32,
    parameter  int RD_LAT = 2,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        cfg_len,
    input  logic [NUM_CH-1:0]        done_req,
    output logic [NUM_CH-1:0]        done_ack,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [NUM_CH-1:0]        rd_en,
    input  logic [NUM_CH*DATA_W-1:0] rd_data,
    prach_buffer_readout_rr_if.master dout
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int IN_D  = DEPTH - 1;
    localparam int PTR_W = $clog2(IN_D);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FL_W  = $clog2(RD_LAT + 1);
    localparam int E_W   = DATA_W + CH_W + 2;
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IN_D - 1);

    typedef enum logic [1:0] {IDLE, GRANT, READ, FLUSH} state_t;

    state_t            state;
    logic [CH_W-1:0]   idx_q;
    logic [CH_W-1:0]   win;
    logic [CH_W-1:0]   start;
    logic [ADDR_W-1:0] len_q;
    logic [FL_W-1:0]   fl_cnt;
    logic              issue;
    logic              is_last;

    logic [RD_LAT-1:0] pv;
    logic [1:0]        ptag [RD_LAT];
    logic [E_W-1:0]    mem  [IN_D];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  inflight;
    logic [E_W-1:0]    out_q;
    logic              dv_q;
    logic [DATA_W-1:0] rd_word;
    logic [E_W-1:0]    wentry;
    logic              push;
    logic              pop;
    logic              load;
    logic              from_mem;
    logic              bypass;
    logic              wr_mem;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Search order starts at start and wraps around the channel list.
    always_comb begin
        int  j;
        logic found;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(start) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && done_req[j]) begin
                found = 1'b1;
                win   = CH_W'(j);
            end
        end
    end

`ifdef PRACH_READOUT_RR_EN
    logic [CH_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == IDLE && |done_req) begin
            rr_ptr <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
    end

    assign start = rr_ptr;
`else
    assign start = '0;
`endif

    // Credit: every issued read already owns a FIFO slot.
    assign fifo_cnt = CNT_W'(dv_q) + in_cnt;
    assign inflight = CNT_W'($countones(pv));
    assign issue    = (state == READ) &&
                      ({1'b0, fifo_cnt} + {1'b0, inflight} <
                       (CNT_W + 1)'(DEPTH));
    assign is_last  = (rd_addr == len_q - 1'b1);
    assign rd_en    = issue ? (ONE << idx_q) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            fl_cnt   <= '0;
            done_ack <= '0;
            rd_addr  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|done_req) begin
                        state    <= GRANT;
                        idx_q    <= win;
                        len_q    <= cfg_len;
                        rd_addr  <= '0;
                        done_ack <= ONE << win;
                    end
                end
                GRANT: state <= READ;
                READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + 1'b1;
                        if (is_last) begin
                            state  <= FLUSH;
                            fl_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (fl_cnt == FL_W'(RD_LAT - 1)) begin
                        state    <= IDLE;
                        done_ack <= '0;
                    end else begin
                        fl_cnt <= fl_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The grant cannot change while reads are in flight, so idx_q
    // is still the source channel when the data lands.
    assign rd_word = rd_data[int'(idx_q)*DATA_W +: DATA_W];
    assign wentry  = {ptag[RD_LAT-1], idx_q, rd_word};
    assign push    = pv[RD_LAT-1];
    assign pop     = dv_q && dout.dout_ready;
    assign load    = !dv_q || pop;
    assign from_mem = load && (in_cnt != '0);
    assign bypass  = load && (in_cnt == '0) && push;
    assign wr_mem  = push && !bypass;

    always_ff @(posedge clk) begin
        if (wr_mem) mem[wp] <= wentry;
    end

    // out_q is the FIFO head; data written into an empty FIFO
    // goes straight to it for RD_LAT+1 latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv     <= '0;
            for (int k = 0; k < RD_LAT; k++) ptag[k] <= '0;
            wp     <= '0;
            rp     <= '0;
            in_cnt <= '0;
            out_q  <= '0;
            dv_q   <= 1'b0;
        end else begin
            pv[0]   <= issue;
            ptag[0] <= {is_last, rd_addr == '0};
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k]   <= pv[k-1];
                ptag[k] <= ptag[k-1];
            end
            if (wr_mem) wp <= nxt(wp);
            if (from_mem) rp <= nxt(rp);
            in_cnt <= in_cnt + CNT_W'(wr_mem) - CNT_W'(from_mem);
            if (load) begin
                if (from_mem) begin
                    out_q <= mem[rp];
                    dv_q  <= 1'b1;
                end else if (push) begin
                    out_q <= wentry;
                    dv_q  <= 1'b1;
                end else begin
                    dv_q  <= 1'b0;
                end
            end
        end
    end

    assign dout.dout_dr  = out_q[DATA_W/2-1:0];
    assign dout.dout_di  = out_q[DATA_W-1:DATA_W/2];
    assign dout.dout_ch  = out_q[DATA_W +: CH_W];
    assign dout.sync_out = out_q[E_W-2];
    assign dout.last_out = out_q[E_W-1];
    assign dout.dout_dv  = dv_q;
endmodule

// File: tb/tb_prach_buffer_readout_rr.sv
// Self-checking bench for prach_buffer_readout_rr with a buffer model
// and a scoreboard of expected samples.
module tb_prach_buffer_readout_rr;
    localparam int NUM_CH = 24;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int CH_W   = 5;
    localparam int DEPTH  = RD_LAT + 2;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [15:0]     dr;
        logic [15:0]     di;
        logic            sync;
        logic            last;
        logic            lat;
        int              icyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [ADDR_W-1:0]        cfg_len = '0;
    logic [NUM_CH-1:0]        done_req = '0;
    logic [NUM_CH-1:0]        done_ack;
    logic [ADDR_W-1:0]        rd_addr;
    logic [NUM_CH-1:0]        rd_en;
    logic [NUM_CH*DATA_W-1:0] rd_data = '0;

    logic [NUM_CH-1:0] h_en [RD_LAT+1];
    logic [ADDR_W-1:0] h_ad [RD_LAT+1];

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   g_iss = 0;
    int   g_acc = 0;

    prach_buffer_readout_rr_if #(.DATA_W(DATA_W), .CH_W(CH_W)) dif();

    prach_buffer_readout_rr #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .done_req(done_req), .done_ack(done_ack),
        .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data), .dout(dif.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int c, input int a);
        return {8'(c), 8'(a), 8'h10 ^ 8'(c), 8'(a)};
    endfunction

    // Buffer model: data valid exactly RD_LAT cycles after the read.
    always @(negedge clk) begin
        for (int k = RD_LAT; k > 0; k--) begin
            h_en[k] = h_en[k-1];
            h_ad[k] = h_ad[k-1];
        end
        h_en[0] = rd_en;
        h_ad[0] = rd_addr;
        for (int c = 0; c < NUM_CH; c++) begin
            if (h_en[RD_LAT][c])
                rd_data[c*DATA_W +: DATA_W] = pat(c, int'(h_ad[RD_LAT]));
            else
                rd_data[c*DATA_W +: DATA_W] = 32'hDEAD0000 | 32'(c);
        end
    end

    task automatic run_block(input int ch, input int len, input int mode,
                             input bit drop, input bit drain,
                             output int ack_cyc);
        int n;
        int guard;
        int last_iss;
        bit seen;
        bit done;
        logic [NUM_CH-1:0] oh;
        exp_t e;
        exp_t a;
        oh = NUM_CH'(1) << ch;
        n = 0; guard = 0; last_iss = 0; seen = 0; done = 0;
        ack_cyc = 0;
        while (!done) begin
            @(negedge clk);
            guard++;
            if (mode == 1) dif.dout_ready = ((cyc / 3) % 2) == 0;
            else dif.dout_ready = 1'b1;
            if (done_ack != '0) begin
                seen = 1;
                ack_cyc++;
                n_chk++;
                if (done_ack !== oh) begin
                    n_fail++;
                    $display("FAIL ack: got %h want %h", done_ack, oh);
                end
                if (drop) done_req[ch] = 1'b0;
            end
            if (rd_en != '0) begin
                n_chk++;
                if (rd_en !== oh || rd_addr !== ADDR_W'(n)) begin
                    n_fail++;
                    $display("FAIL issue: got en=%h addr=%0d want en=%h addr=%0d",
                             rd_en, rd_addr, oh, n);
                end
                if (mode == 0 && n > 0) begin
                    n_chk++;
                    if (cyc - last_iss != 1) begin
                        n_fail++;
                        $display("FAIL issue_gap: got %0d want 1", cyc - last_iss);
                    end
                end
                last_iss = cyc;
                e.ch   = CH_W'(ch);
                e.dr   = {8'h10 ^ 8'(ch), 8'(n)};
                e.di   = {8'(ch), 8'(n)};
                e.sync = (n == 0);
                e.last = (n == len - 1);
                e.lat  = (mode == 0);
                e.icyc = cyc;
                sb.push_back(e);
                n++;
                g_iss++;
            end
            if (dif.dout_dv && dif.dout_ready) begin
                g_acc++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_sample: got ch=%0d dr=%h want none",
                             dif.dout_ch, dif.dout_dr);
                end else begin
                    a = sb.pop_front();
                    if (dif.dout_ch !== a.ch || dif.dout_dr !== a.dr ||
                        dif.dout_di !== a.di || dif.sync_out !== a.sync ||
                        dif.last_out !== a.last) begin
                        n_fail++;
                        $display("FAIL sample: got ch=%0d dr=%h di=%h s=%b l=%b want ch=%0d dr=%h di=%h s=%b l=%b",
                                 dif.dout_ch, dif.dout_dr, dif.dout_di,
                                 dif.sync_out, dif.last_out, a.ch, a.dr,
                                 a.di, a.sync, a.last);
                    end
                    if (a.lat) begin
                        n_chk++;
                        if (cyc - a.icyc != RD_LAT + 1) begin
                            n_fail++;
                            $display("FAIL latency: got %0d want %0d",
                                     cyc - a.icyc, RD_LAT + 1);
                        end
                    end
                end
            end
            if (mode == 1) begin
                n_chk++;
                if (g_iss - g_acc > DEPTH) begin
                    n_fail++;
                    $display("FAIL occupancy: got %0d want <= %0d",
                             g_iss - g_acc, DEPTH);
                end
            end
            if (seen && done_ack == '0 && (!drain || sb.size() == 0))
                done = 1;
            if (guard > 400) begin
                n_fail++;
                $display("FAIL timeout: ch %0d got %0d reads want %0d", ch, n, len);
                done = 1;
            end
        end
        n_chk++;
        if (n != len) begin
            n_fail++;
            $display("FAIL read_count: got %0d want %0d", n, len);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (done_ack !== '0 || rd_en !== '0 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got ack=%h en=%h addr=%h want 0",
                     done_ack, rd_en, rd_addr);
        end
        n_chk++;
        if (dif.dout_dv !== 1'b0 || dif.dout_dr !== '0 || dif.dout_di !== '0 ||
            dif.dout_ch !== '0 || dif.sync_out !== 1'b0 || dif.last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dout: got dv=%b dr=%h di=%h ch=%0d want 0",
                     dif.dout_dv, dif.dout_dr, dif.dout_di, dif.dout_ch);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_block();
        int ac;
        cfg_len = 4'd4;
        done_req[5] = 1'b1;
        run_block(5, 4, 0, 1, 1, ac);
        n_chk++;
        if (ac != 4 + RD_LAT + 1) begin
            n_fail++;
            $display("FAIL single_ack_len: got %0d want %0d", ac, 4 + RD_LAT + 1);
        end
    endtask

    task automatic test_arbitration();
        int ord [4];
        int ac;
`ifdef PRACH_READOUT_RR_EN
        // last grant was channel 5, so the search resumes at 6
        ord = '{7, 0, 7, 0};
`else
        ord = '{0, 0, 0, 0};
`endif
        cfg_len = 4'd3;
        done_req[0] = 1'b1;
        done_req[7] = 1'b1;
        for (int i = 0; i < 4; i++)
            run_block(ord[i], 3, 0, 0, i == 3, ac);
        done_req = '0;
    endtask

    task automatic test_backpressure();
        int ac;
        cfg_len = '0;
        done_req[11] = 1'b1;
        run_block(11, 16, 1, 1, 1, ac);
        dif.dout_ready = 1'b1;
    endtask

    task automatic test_wrap();
        int ac;
        cfg_len = '0;
        done_req[2] = 1'b1;
        run_block(2, 16, 0, 1, 1, ac);
        n_chk++;
        if (rd_addr !== '0) begin
            n_fail++;
            $display("FAIL wrap_addr: got %0d want 0", rd_addr);
        end
    endtask

    task automatic test_len1();
        int ac;
        cfg_len = 4'd1;
        done_req[20] = 1'b1;
        run_block(20, 1, 0, 1, 1, ac);
        n_chk++;
        if (ac != RD_LAT + 2) begin
            n_fail++;
            $display("FAIL len1_ack: got %0d want %0d", ac, RD_LAT + 2);
        end
    endtask

    task automatic test_abort();
        int  ac;
        bit  hit;
        hit = 0;
        cfg_len = '0;
        done_req[3] = 1'b1;
        dif.dout_ready = 1'b1;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (rd_en != '0 && rd_addr == 4'd7) hit = 1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_reach: got no read at addr 7 want one");
        end
        rst_n = 1'b0;
        done_req = '0;
        @(negedge clk);
        n_chk++;
        if (done_ack !== '0 || rd_en !== '0 || rd_addr !== '0 ||
            dif.dout_dv !== 1'b0 || dif.sync_out !== 1'b0 ||
            dif.last_out !== 1'b0 || dif.dout_dr !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: got ack=%h en=%h addr=%0d dv=%b want 0",
                     done_ack, rd_en, rd_addr, dif.dout_dv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        g_iss = 0;
        g_acc = 0;
        cfg_len = 4'd4;
        done_req[9] = 1'b1;
        run_block(9, 4, 0, 1, 1, ac);
        n_chk++;
        if (ac != 4 + RD_LAT + 1) begin
            n_fail++;
            $display("FAIL abort_restart_ack: got %0d want %0d", ac, 4 + RD_LAT + 1);
        end
    endtask

    initial begin
        for (int k = 0; k <= RD_LAT; k++) begin
            h_en[k] = '0;
            h_ad[k] = '0;
        end
        dif.dout_ready = 1'b1;
        test_reset();
        test_single_block();
        test_arbitration();
        test_backpressure();
        test_wrap();
        test_len1();
        test_abort();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d samples want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
